// File: rtl/window_crop.sv
// window_crop: crops the YUV pixel stream to a programmable window and
// re-frames the FS/RS/RE/FE markers so the output is a consistent image.
module window_crop #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DIM_WIDTH   = 16,
    parameter int DTYPE_WIDTH = 4,
    parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(1),
    parameter logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(2),
    parameter logic [DTYPE_WIDTH-1:0] DT_ROW_START   = DTYPE_WIDTH'(3),
    parameter logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(4),
    parameter logic [DTYPE_WIDTH-1:0] DT_PIXEL       = DTYPE_WIDTH'(5)
) (
    input  logic                   pixclk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic [DIM_WIDTH-1:0]   col_start,
    input  logic [DIM_WIDTH-1:0]   col_end,
    input  logic [DIM_WIDTH-1:0]   row_start,
    input  logic [DIM_WIDTH-1:0]   row_end,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]            meta_datai,
    input  logic [PIXEL_WIDTH-1:0] yi,
    input  logic [PIXEL_WIDTH-1:0] ui,
    input  logic [PIXEL_WIDTH-1:0] vi,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]            meta_datao,
    output logic [PIXEL_WIDTH-1:0] yo,
    output logic [PIXEL_WIDTH-1:0] uo,
    output logic [PIXEL_WIDTH-1:0] vo,
    output logic [DIM_WIDTH-1:0]   out_cols,
    output logic [DIM_WIDTH-1:0]   out_rows
);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_MAX  = '1;
    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = '0;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);

    state_t               state;

    // Window shadow, frozen for the whole frame at FRAME_START.
    logic                 en_s;
    logic                 win_ok_s;
    logic [DIM_WIDTH-1:0] cs_s;
    logic [DIM_WIDTH-1:0] ce_s;
    logic [DIM_WIDTH-1:0] rs_s;
    logic [DIM_WIDTH-1:0] re_s;

    logic [DIM_WIDTH-1:0] row_cnt;
    logic [DIM_WIDTH-1:0] col_cnt;
    logic [DIM_WIDTH-1:0] col_acc;
    logic [DIM_WIDTH-1:0] row_w;
    logic [DIM_WIDTH-1:0] rows_acc;

    logic is_idle;
    logic is_fs;
    logic is_fe;
    logic is_rs;
    logic is_re;
    logic is_px;
    logic is_other;
    logic in_frame;
    logic row_keep;
    logic col_keep;
    logic emit;

    function automatic logic [DIM_WIDTH-1:0] sat_inc(
        input logic [DIM_WIDTH-1:0] v
    );
        return (v == DIM_MAX) ? v : v + DIM_ONE;
    endfunction

    // Decode the incoming word and decide whether it is forwarded.
    always_comb begin
        is_idle  = !dvi;
        is_fs    = dvi && (dtypei == DT_FRAME_START);
        is_fe    = dvi && (dtypei == DT_FRAME_END);
        is_rs    = dvi && (dtypei == DT_ROW_START);
        is_re    = dvi && (dtypei == DT_ROW_END);
        is_px    = dvi && (dtypei == DT_PIXEL);
        is_other = dvi && !(is_fs || is_fe || is_rs || is_re || is_px);
        in_frame = (state == IN_FRAME);
        row_keep = !en_s ||
                   (win_ok_s && (row_cnt >= rs_s) && (row_cnt <= re_s));
        col_keep = !en_s || ((col_cnt >= cs_s) && (col_cnt <= ce_s));
        emit     = 1'b0;
        unique case (1'b1)
            is_other: emit = 1'b1;
            is_fs:    emit = 1'b1;
            is_rs:    emit = in_frame && row_keep;
            is_px:    emit = in_frame && row_keep && col_keep;
            is_re:    emit = in_frame && row_keep;
            is_fe:    emit = in_frame;
            default:  emit = 1'b0;
        endcase
    end

    // Frame FSM, window counters, status and registered output word.
    always_ff @(posedge pixclk) begin
        if (!resetb) begin
            state      <= IDLE;
            en_s       <= 1'b0;
            win_ok_s   <= 1'b0;
            cs_s       <= DIM_ZERO;
            ce_s       <= DIM_ZERO;
            rs_s       <= DIM_ZERO;
            re_s       <= DIM_ZERO;
            row_cnt    <= DIM_ZERO;
            col_cnt    <= DIM_ZERO;
            col_acc    <= DIM_ZERO;
            row_w      <= DIM_ZERO;
            rows_acc   <= DIM_ZERO;
            out_cols   <= DIM_ZERO;
            out_rows   <= DIM_ZERO;
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            yo         <= '0;
            uo         <= '0;
            vo         <= '0;
        end else begin
            dvo <= emit;
            if (emit) begin
                dtypeo     <= dtypei;
                meta_datao <= meta_datai;
                yo         <= yi;
                uo         <= ui;
                vo         <= vi;
            end
            unique case (1'b1)
                is_fs: begin
                    // A start inside a frame closes the lost frame first.
                    if (in_frame) begin
                        out_cols <= row_w;
                        out_rows <= rows_acc;
                    end
                    en_s     <= enable;
                    win_ok_s <= (col_start <= col_end) &&
                                (row_start <= row_end);
                    cs_s     <= col_start;
                    ce_s     <= col_end;
                    rs_s     <= row_start;
                    re_s     <= row_end;
                    row_cnt  <= DIM_ZERO;
                    col_cnt  <= DIM_ZERO;
                    col_acc  <= DIM_ZERO;
                    row_w    <= DIM_ZERO;
                    rows_acc <= DIM_ZERO;
                    state    <= IN_FRAME;
                end
                is_rs: begin
                    if (in_frame) begin
                        col_cnt <= DIM_ZERO;
                        col_acc <= DIM_ZERO;
                    end
                end
                is_px: begin
                    if (in_frame) begin
                        col_cnt <= sat_inc(col_cnt);
                        if (row_keep && col_keep) begin
                            col_acc <= sat_inc(col_acc);
                        end
                    end
                end
                is_re: begin
                    if (in_frame) begin
                        row_cnt <= sat_inc(row_cnt);
                        if (row_keep) begin
                            rows_acc <= sat_inc(rows_acc);
                            row_w    <= col_acc;
                        end
                    end
                end
                is_fe: begin
                    if (in_frame) begin
                        out_cols <= row_w;
                        out_rows <= rows_acc;
                        state    <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_crop.sv
// tb_window_crop: directed and randomized frames checked against a
// row/column window model built from frame geometry.
module tb_window_crop;

    localparam int PW = 10;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam logic [TW-1:0] FS = 4'd1;
    localparam logic [TW-1:0] FE = 4'd2;
    localparam logic [TW-1:0] RS = 4'd3;
    localparam logic [TW-1:0] RE = 4'd4;
    localparam logic [TW-1:0] PX = 4'd5;

    logic          pixclk = 1'b0;
    logic          resetb = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] col_start = '0;
    logic [DW-1:0] col_end = '0;
    logic [DW-1:0] row_start = '0;
    logic [DW-1:0] row_end = '0;
    logic          dvi = 1'b0;
    logic [TW-1:0] dtypei = '0;
    logic [15:0]   meta_datai = '0;
    logic [PW-1:0] yi = '0;
    logic [PW-1:0] ui = '0;
    logic [PW-1:0] vi = '0;
    logic          dvo;
    logic [TW-1:0] dtypeo;
    logic [15:0]   meta_datao;
    logic [PW-1:0] yo;
    logic [PW-1:0] uo;
    logic [PW-1:0] vo;
    logic [DW-1:0] out_cols;
    logic [DW-1:0] out_rows;

    window_crop dut (
        .pixclk(pixclk), .resetb(resetb), .enable(enable),
        .col_start(col_start), .col_end(col_end),
        .row_start(row_start), .row_end(row_end),
        .dvi(dvi), .dtypei(dtypei), .meta_datai(meta_datai),
        .yi(yi), .ui(ui), .vi(vi),
        .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao),
        .yo(yo), .uo(uo), .vo(vo),
        .out_cols(out_cols), .out_rows(out_rows)
    );

    always #5 pixclk = ~pixclk;

    int checks = 0;
    int failures = 0;

    logic [TW-1:0] l_dt = '0;
    logic [15:0]   l_meta = '0;
    logic [PW-1:0] l_y = '0;
    logic [PW-1:0] l_u = '0;
    logic [PW-1:0] l_v = '0;
    int exp_cols = 0;
    int exp_rows = 0;
    int pend_cols = 0;
    int pend_rows = 0;
    bit pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One input word; expected output is the word itself when kept.
    task automatic word(input bit v, input logic [TW-1:0] dt,
                        input bit keep, input bit rst);
        dvi        = v;
        dtypei     = dt;
        meta_datai = 16'($urandom);
        yi         = PW'($urandom);
        ui         = PW'($urandom);
        vi         = PW'($urandom);
        if (rst) resetb = 1'b0;
        @(posedge pixclk);
        @(negedge pixclk);
        if (rst) begin
            resetb   = 1'b1;
            l_dt     = '0;
            l_meta   = '0;
            l_y      = '0;
            l_u      = '0;
            l_v      = '0;
            exp_cols = 0;
            exp_rows = 0;
            pend     = 0;
        end else if (v && keep) begin
            l_dt   = dt;
            l_meta = meta_datai;
            l_y    = yi;
            l_u    = ui;
            l_v    = vi;
        end
        chk("dvo", 32'(dvo), 32'(v && keep && !rst));
        chk("dtypeo", 32'(dtypeo), 32'(l_dt));
        chk("meta_datao", 32'(meta_datao), 32'(l_meta));
        chk("yo", 32'(yo), 32'(l_y));
        chk("uo", 32'(uo), 32'(l_u));
        chk("vo", 32'(vo), 32'(l_v));
        chk("out_cols", 32'(out_cols), 32'(exp_cols));
        chk("out_rows", 32'(out_rows), 32'(exp_rows));
        dvi = 1'b0;
    endtask

    task automatic noise_word();
        if ($urandom_range(1, 0) == 0)
            word(0, TW'($urandom), 0, 0);
        else
            word(1, TW'(6 + $urandom_range(9, 0)), 1, 0);
    endtask

    task automatic frame(input int cols, input int rows, input bit en,
                         input int cs, input int ce, input int rs,
                         input int re, input int rst_at, input bit chg,
                         input bit no_fe, input bit noise);
        int kr;
        int lastw;
        int idx;
        int w;
        bit alive;
        bit vw;
        bit rk;
        bit ck;
        kr    = 0;
        lastw = 0;
        idx   = 0;
        alive = 1;
        vw    = (cs <= ce) && (rs <= re);
        enable    = en;
        col_start = DW'(cs);
        col_end   = DW'(ce);
        row_start = DW'(rs);
        row_end   = DW'(re);
        if (pend) begin
            exp_cols = pend_cols;
            exp_rows = pend_rows;
            pend     = 0;
        end
        word(1, FS, 1, 0);
        for (int r = 0; r < rows; r++) begin
            rk = !en || (vw && r >= rs && r <= re);
            if (chg && r == 1) begin
                col_start = '0;
                col_end   = '0;
                row_start = '0;
                row_end   = '0;
                enable    = !en;
            end
            word(1, RS, alive && rk, 0);
            w = 0;
            for (int c = 0; c < cols; c++) begin
                ck = !en || (c >= cs && c <= ce);
                if (noise && $urandom_range(3, 0) == 0) noise_word();
                idx++;
                if (idx == rst_at) begin
                    word(1, PX, 0, 1);
                    alive = 0;
                end else begin
                    word(1, PX, alive && rk && ck, 0);
                    if (alive && rk && ck) w++;
                end
            end
            word(1, RE, alive && rk, 0);
            if (alive && rk) begin
                kr++;
                lastw = w;
            end
        end
        if (no_fe) begin
            if (alive) begin
                pend      = 1;
                pend_cols = lastw;
                pend_rows = kr;
            end
        end else begin
            if (alive) begin
                exp_cols = lastw;
                exp_rows = kr;
            end
            word(1, FE, alive, 0);
        end
    endtask

    initial begin
        int c;
        int r;
        resetb = 1'b0;
        @(posedge pixclk);
        @(posedge pixclk);
        @(negedge pixclk);
        chk("rst_dvo", 32'(dvo), 32'd0);
        chk("rst_dtypeo", 32'(dtypeo), 32'd0);
        chk("rst_meta", 32'(meta_datao), 32'd0);
        chk("rst_yo", 32'(yo), 32'd0);
        chk("rst_uo", 32'(uo), 32'd0);
        chk("rst_vo", 32'(vo), 32'd0);
        chk("rst_out_cols", 32'(out_cols), 32'd0);
        chk("rst_out_rows", 32'(out_rows), 32'd0);
        resetb = 1'b1;

        frame(8, 4, 1, 2, 5, 1, 2, -1, 0, 0, 0);
        chk("crop_cols", 32'(out_cols), 32'd4);
        chk("crop_rows", 32'(out_rows), 32'd2);

        frame(8, 4, 0, 2, 5, 1, 2, -1, 0, 0, 0);
        chk("pass_cols", 32'(out_cols), 32'd8);
        chk("pass_rows", 32'(out_rows), 32'd4);

        frame(8, 4, 1, 2, 5, 1, 2, -1, 1, 0, 0);
        chk("shadow_cols", 32'(out_cols), 32'd4);
        frame(8, 4, 1, 0, 0, 0, 3, -1, 0, 0, 0);
        chk("narrow_cols", 32'(out_cols), 32'd1);
        chk("narrow_rows", 32'(out_rows), 32'd4);

        frame(8, 4, 1, 5, 2, 1, 2, -1, 0, 0, 0);
        chk("inv_cols", 32'(out_cols), 32'd0);
        chk("inv_rows", 32'(out_rows), 32'd0);

        word(1, PX, 0, 0);
        word(1, PX, 0, 0);
        word(1, RE, 0, 0);
        word(1, 4'd7, 1, 0);
        word(1, RS, 0, 0);
        word(1, PX, 0, 0);
        word(1, FE, 0, 0);
        frame(6, 3, 1, 1, 3, 0, 1, -1, 0, 0, 0);
        chk("join_cols", 32'(out_cols), 32'd3);
        chk("join_rows", 32'(out_rows), 32'd2);

        frame(8, 4, 1, 2, 5, 1, 2, 11, 0, 0, 0);
        chk("rst_mid_cols", 32'(out_cols), 32'd0);
        frame(8, 4, 1, 2, 5, 1, 2, -1, 0, 0, 0);

        frame(5, 3, 1, 0, 2, 1, 2, -1, 0, 1, 0);
        frame(4, 2, 1, 1, 1, 0, 0, -1, 0, 0, 0);
        chk("refs_cols", 32'(out_cols), 32'd1);
        chk("refs_rows", 32'(out_rows), 32'd1);

        for (int i = 0; i < 10; i++) begin
            c = $urandom_range(12, 1);
            r = $urandom_range(6, 1);
            frame(c, r, $urandom_range(3, 0) != 0,
                  $urandom_range(13, 0), $urandom_range(13, 0),
                  $urandom_range(7, 0), $urandom_range(7, 0),
                  -1, 0, $urandom_range(4, 0) == 0, 1);
        end
        frame(3, 2, 1, 0, 1, 0, 1, -1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
